// File: rtl/cmult_pkg.sv
// -----------------------------------------------------------------------------
// cmult_pkg
//   Shared constants, types and helpers for the complex multiplier / MAC.
//   - LAT            : sample-to-result latency in clock cycles
//   - MAXW           : working width of the round/saturate helpers. The
//                      accumulator is sign-extended to this width before it is
//                      rounded, so ACCW must stay below MAXW.
//   - frame_state_t  : accumulate-frame FSM encoding
//   - prod_w/acc_w   : width of the exact complex product and of the accumulator
//   - round_shift    : arithmetic shift right with round-half-up
//   - sat_check      : 1 when a value does not fit a signed field of width ow
//   - sat_clamp      : clamp a value to the range of a signed field of width ow
// -----------------------------------------------------------------------------
package cmult_pkg;

  localparam int LAT  = 6;
  localparam int MAXW = 128;

  typedef enum logic {
    FRAME_IDLE = 1'b0,
    FRAME_OPEN = 1'b1
  } frame_state_t;

  // Exact complex product: |ar*br - ai*bi'| can reach 2^(aw+bw-1) when bi'
  // is the negated most-negative value, so one extra bit over aw+bw.
  function automatic int prod_w(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

  function automatic int acc_w(input int aw, input int bw, input int guard);
    return aw + bw + 1 + guard;
  endfunction

  // (v + 2^(shift-1)) >>> shift, no bias when shift is 0.
  function automatic logic signed [MAXW-1:0] round_shift(
    input logic signed [MAXW-1:0] v,
    input int                     shift
  );
    logic signed [MAXW-1:0] bias;
    bias = '0;
    if (shift > 0) begin
      bias = MAXW'(1) << (shift - 1);
    end
    return (v + bias) >>> shift;
  endfunction

  function automatic logic sat_check(
    input logic signed [MAXW-1:0] r,
    input int                     ow
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (MAXW'(1) << (ow - 1)) - MAXW'(1);
    lo = ~hi;  // equals -hi-1, i.e. -2^(ow-1)
    return (r > hi) || (r < lo);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_clamp(
    input logic signed [MAXW-1:0] r,
    input int                     ow
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (MAXW'(1) << (ow - 1)) - MAXW'(1);
    lo = ~hi;
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmult_core.sv
// -----------------------------------------------------------------------------
// cmult_core
//   Four-stage pipelined complex product p = a*b or a*conj(b) built from three
//   real multipliers:
//     m0 = (ar-ai)*bi',  mr = (br-bi')*ar,  mi = (br+bi')*ai
//     pr = mr + m0 = ar*br - ai*bi'
//     pi = mi + m0 = ar*bi' + ai*br
//   where bi' = conj_en ? -bi : bi.
//
//   Handshake: in_valid is a one-cycle sample strobe with no backpressure; the
//   block accepts a sample on every cycle in which in_valid is high.
//   prod_valid is the same strobe delayed by four cycles, with prod_last and
//   prod_acc travelling beside it (both already qualified by in_valid).
//
// Ports
//   clk, rst      : clock, synchronous active-high reset (valid/control pipe only)
//   in_valid      : sample strobe
//   in_last       : last sample of an accumulate frame
//   acc_en        : sample belongs to an accumulate frame
//   conj_en       : multiply by conj(b)
//   ar, ai        : operand a, signed AWIDTH
//   br, bi        : operand b, signed BWIDTH
//   prod_valid    : product strobe, 4 cycles after in_valid
//   prod_last     : in_last of that sample
//   prod_acc      : acc_en of that sample
//   prod_r/prod_i : exact product, signed prod_w(AWIDTH,BWIDTH) bits
// -----------------------------------------------------------------------------
module cmult_core
  import cmult_pkg::*;
#(
  parameter int AWIDTH = 18,
  parameter int BWIDTH = 18
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic                              acc_en,
  input  logic                              conj_en,
  input  logic [AWIDTH-1:0]                 ar,
  input  logic [AWIDTH-1:0]                 ai,
  input  logic [BWIDTH-1:0]                 br,
  input  logic [BWIDTH-1:0]                 bi,
  output logic                              prod_valid,
  output logic                              prod_last,
  output logic                              prod_acc,
  output logic [prod_w(AWIDTH, BWIDTH)-1:0] prod_r,
  output logic [prod_w(AWIDTH, BWIDTH)-1:0] prod_i
);

  localparam int PW = prod_w(AWIDTH, BWIDTH);
  // Multiplier output width: every partial product is (AWIDTH+1)x(BWIDTH+1)
  // or AWIDTH x (BWIDTH+2) bits, both AWIDTH+BWIDTH+2 bits at full precision.
  localparam int MW = PW + 1;

  // Valid/control pipe, index 0 = S1 ... index 3 = S4.
  logic [3:0] vld;
  logic [3:0] lst;
  logic [3:0] acc;

  // S1
  logic signed [AWIDTH-1:0] ar1;
  logic signed [AWIDTH-1:0] ai1;
  logic signed [BWIDTH-1:0] br1;
  logic signed [BWIDTH:0]   bi1;
  // S2
  logic signed [AWIDTH:0]   c2;
  logic signed [BWIDTH+1:0] dr2;
  logic signed [BWIDTH+1:0] di2;
  logic signed [AWIDTH-1:0] ar2;
  logic signed [AWIDTH-1:0] ai2;
  logic signed [BWIDTH:0]   bi2;
  // S3
  logic signed [MW-1:0]     m0;
  logic signed [MW-1:0]     mr;
  logic signed [MW-1:0]     mi;

  // bi is widened by one bit so that negating -2^(BWIDTH-1) stays exact.
  logic signed [BWIDTH:0]   bi_ext;
  assign bi_ext = {bi[BWIDTH-1], bi};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
      acc <= '0;
    end else begin
      vld <= {vld[2:0], in_valid};
      lst <= {lst[2:0], in_valid & in_last};
      acc <= {acc[2:0], in_valid & acc_en};
    end
  end

  // Datapath registers carry no reset; each stage loads only when its input
  // stage holds a valid sample.
  always_ff @(posedge clk) begin
    // S1: capture operands, apply conjugation
    if (in_valid) begin
      ar1 <= ar;
      ai1 <= ai;
      br1 <= br;
      bi1 <= conj_en ? -bi_ext : bi_ext;
    end
    // S2: pre-adders
    if (vld[0]) begin
      c2  <= {ar1[AWIDTH-1], ar1} - {ai1[AWIDTH-1], ai1};
      dr2 <= {{2{br1[BWIDTH-1]}}, br1} - {bi1[BWIDTH], bi1};
      di2 <= {{2{br1[BWIDTH-1]}}, br1} + {bi1[BWIDTH], bi1};
      ar2 <= ar1;
      ai2 <= ai1;
      bi2 <= bi1;
    end
    // S3: three full-precision multipliers
    if (vld[1]) begin
      m0 <= MW'(c2)  * MW'(bi2);
      mr <= MW'(dr2) * MW'(ar2);
      mi <= MW'(di2) * MW'(ai2);
    end
    // S4: post-adders; the true result always fits PW bits, so the top bit
    // of the MW-bit sum is redundant.
    if (vld[2]) begin
      prod_r <= PW'(mr + m0);
      prod_i <= PW'(mi + m0);
    end
  end

  assign prod_valid = vld[3];
  assign prod_last  = lst[3];
  assign prod_acc   = acc[3];

endmodule

// File: rtl/cmult_mac.sv
// -----------------------------------------------------------------------------
// cmult_mac
//   Pipelined complex multiplier / multiply-accumulator. Each valid sample
//   produces p = a*b or a*conj(b); samples can be summed over a frame closed by
//   in_last. Results are rounded (half up) after an arithmetic right shift of
//   SHIFT bits and saturated to OWIDTH bits. Latency from in_valid to out_valid
//   is LAT = 6 cycles, full throughput.
//
//   Handshake: in_valid is a one-cycle sample strobe with no backpressure; all
//   input fields are ignored while it is low. out_valid is a one-cycle result
//   strobe; pr/pi/out_sat hold their value between strobes.
//
//   The frame FSM state is held in the internal signal frame_state
//   (frame_state_t) at stage S5.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : sample strobe
//   in_last     : last sample of an accumulate frame (only with acc_en=1)
//   acc_en      : 1 = accumulate into the open frame, 0 = single product
//   conj_en     : 1 = use conj(b)
//   ar, ai      : operand a, signed AWIDTH
//   br, bi      : operand b, signed BWIDTH
//   clr_ovf     : clears ovf_sticky
//   out_valid   : result strobe
//   pr, pi      : result, signed OWIDTH
//   out_sat     : pr or pi saturated on this result
//   ovf_sticky  : set by any saturated result, cleared by rst or clr_ovf
// -----------------------------------------------------------------------------
module cmult_mac
  import cmult_pkg::*;
#(
  parameter int AWIDTH = 18,
  parameter int BWIDTH = 18,
  parameter int GUARD  = 8,
  parameter int SHIFT  = 0,
  parameter int OWIDTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              acc_en,
  input  logic              conj_en,
  input  logic [AWIDTH-1:0] ar,
  input  logic [AWIDTH-1:0] ai,
  input  logic [BWIDTH-1:0] br,
  input  logic [BWIDTH-1:0] bi,
  input  logic              clr_ovf,
  output logic              out_valid,
  output logic [OWIDTH-1:0] pr,
  output logic [OWIDTH-1:0] pi,
  output logic              out_sat,
  output logic              ovf_sticky
);

  localparam int PW   = prod_w(AWIDTH, BWIDTH);
  localparam int ACCW = acc_w(AWIDTH, BWIDTH, GUARD);

  logic          prod_valid;
  logic          prod_last;
  logic          prod_acc;
  logic [PW-1:0] prod_r;
  logic [PW-1:0] prod_i;

  cmult_core #(
    .AWIDTH (AWIDTH),
    .BWIDTH (BWIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .acc_en     (acc_en),
    .conj_en    (conj_en),
    .ar         (ar),
    .ai         (ai),
    .br         (br),
    .bi         (bi),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_acc   (prod_acc),
    .prod_r     (prod_r),
    .prod_i     (prod_i)
  );

  // ---------------------------------------------------------------------------
  // S5: frame FSM and accumulator
  // ---------------------------------------------------------------------------
  logic signed [ACCW-1:0] prod_r_ext;
  logic signed [ACCW-1:0] prod_i_ext;
  logic signed [ACCW-1:0] acc_r;
  logic signed [ACCW-1:0] acc_i;
  frame_state_t           frame_state;
  logic                   res_valid;

  assign prod_r_ext = ACCW'(signed'(prod_r));
  assign prod_i_ext = ACCW'(signed'(prod_i));

  // A result leaves S5 for every single-product sample and for the last
  // sample of a frame. A single-product sample arriving in an open frame
  // abandons the partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state <= FRAME_IDLE;
      res_valid   <= 1'b0;
    end else begin
      res_valid <= prod_valid && (!prod_acc || prod_last);
      if (prod_valid) begin
        if (!prod_acc || prod_last) begin
          frame_state <= FRAME_IDLE;
        end else begin
          frame_state <= FRAME_OPEN;
        end
      end
    end
  end

  // The accumulator is (re)loaded by the first sample of every frame, so it
  // needs no reset. Frames longer than 2^GUARD samples wrap silently.
  always_ff @(posedge clk) begin
    if (prod_valid) begin
      if (!prod_acc || (frame_state == FRAME_IDLE)) begin
        acc_r <= prod_r_ext;
        acc_i <= prod_i_ext;
      end else begin
        acc_r <= acc_r + prod_r_ext;
        acc_i <= acc_i + prod_i_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S6: round, saturate, output registers
  // ---------------------------------------------------------------------------
  logic signed [MAXW-1:0] rnd_r;
  logic signed [MAXW-1:0] rnd_i;
  logic                   sat_r;
  logic                   sat_i;
  logic [OWIDTH-1:0]      y_r;
  logic [OWIDTH-1:0]      y_i;

  assign rnd_r = round_shift(MAXW'(acc_r), SHIFT);
  assign rnd_i = round_shift(MAXW'(acc_i), SHIFT);
  assign sat_r = sat_check(rnd_r, OWIDTH);
  assign sat_i = sat_check(rnd_i, OWIDTH);
  assign y_r   = OWIDTH'(sat_clamp(rnd_r, OWIDTH));
  assign y_i   = OWIDTH'(sat_clamp(rnd_i, OWIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pr         <= '0;
      pi         <= '0;
      out_sat    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= res_valid;
      if (res_valid) begin
        pr      <= y_r;
        pi      <= y_i;
        out_sat <= sat_r | sat_i;
      end
      // Setting wins over clr_ovf in the same cycle.
      if (res_valid && (sat_r || sat_i)) begin
        ovf_sticky <= 1'b1;
      end else if (clr_ovf) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmult_mac.sv
// -----------------------------------------------------------------------------
// tb_cmult_mac
//   Bench for cmult_mac. u_dut runs with default parameters, u_dut_s2 with
//   SHIFT=2; both share the same stimulus. The reference model works on plain
//   longint complex arithmetic and a frame flag, producing {sat, pr, pi} words
//   and the cycle each result is due.
// -----------------------------------------------------------------------------
module tb_cmult_mac;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int OW = 24;
  localparam int W  = 2 * OW + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic in_valid, in_last, acc_en, conj_en, clr_ovf;
  logic [AW-1:0] ar, ai;
  logic [BW-1:0] br, bi;
  logic          out_valid, out_sat, ovf_sticky;
  logic [OW-1:0] pr, pi;
  logic          out_valid2, out_sat2, ovf_sticky2;
  logic [OW-1:0] pr2, pi2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmult_mac u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_last (in_last),
    .acc_en (acc_en), .conj_en (conj_en), .ar (ar), .ai (ai), .br (br), .bi (bi),
    .clr_ovf (clr_ovf), .out_valid (out_valid), .pr (pr), .pi (pi),
    .out_sat (out_sat), .ovf_sticky (ovf_sticky)
  );

  cmult_mac #(.SHIFT(2)) u_dut_s2 (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_last (in_last),
    .acc_en (acc_en), .conj_en (conj_en), .ar (ar), .ai (ai), .br (br), .bi (bi),
    .clr_ovf (clr_ovf), .out_valid (out_valid2), .pr (pr2), .pi (pi2),
    .out_sat (out_sat2), .ovf_sticky (ovf_sticky2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp2_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] obs_q[$];
  logic [W-1:0] obs2_q[$];
  int           obs_cyc_q[$];
  int           obs2_cyc_q[$];

  // Record every result strobe of both instances.
  always @(negedge clk) begin
    if (out_valid) begin
      obs_q.push_back({out_sat, pr, pi});
      obs_cyc_q.push_back(cyc);
    end
    if (out_valid2) begin
      obs2_q.push_back({out_sat2, pr2, pi2});
      obs2_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  bit     m_open = 1'b0;
  longint m_sum_r = 0;
  longint m_sum_i = 0;

  function automatic logic [W-1:0] pack_ref(input longint sr, input longint si, input int sh);
    longint yr, yi, hi, lo, bias;
    logic   sat;
    bias = (sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0);
    yr   = (sr + bias) >>> sh;
    yi   = (si + bias) >>> sh;
    hi   = (longint'(1) <<< (OW - 1)) - 1;
    lo   = -(longint'(1) <<< (OW - 1));
    sat  = 1'b0;
    if (yr > hi) begin yr = hi; sat = 1'b1; end
    if (yr < lo) begin yr = lo; sat = 1'b1; end
    if (yi > hi) begin yi = hi; sat = 1'b1; end
    if (yi < lo) begin yi = lo; sat = 1'b1; end
    return {sat, yr[OW-1:0], yi[OW-1:0]};
  endfunction

  function automatic void model_sample(input int a_r, input int a_i, input int b_r,
                                       input int b_i, input bit conj, input bit acc,
                                       input bit last);
    longint bq, p_r, p_i;
    bit     emit;
    bq  = conj ? -longint'(b_i) : longint'(b_i);
    p_r = longint'(a_r) * b_r - longint'(a_i) * bq;
    p_i = longint'(a_r) * bq + longint'(a_i) * b_r;
    emit = 1'b0;
    if (!acc) begin
      m_sum_r = p_r;
      m_sum_i = p_i;
      m_open  = 1'b0;
      emit    = 1'b1;
    end else begin
      if (m_open) begin
        m_sum_r += p_r;
        m_sum_i += p_i;
      end else begin
        m_sum_r = p_r;
        m_sum_i = p_i;
      end
      m_open = !last;
      emit   = last;
    end
    if (emit) begin
      exp_q.push_back(pack_ref(m_sum_r, m_sum_i, 0));
      exp2_q.push_back(pack_ref(m_sum_r, m_sum_i, 2));
      exp_cyc_q.push_back(cyc + 6);
    end
  endfunction

  // ---------------- driver tasks ----------------
  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(0, hi - lo)) + lo;
  endfunction

  task automatic junk_inputs();
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    acc_en   = 1'($urandom);
    conj_en  = 1'($urandom);
    ar = AW'($urandom);
    ai = AW'($urandom);
    br = BW'($urandom);
    bi = BW'($urandom);
  endtask

  task automatic send(input int a_r, input int a_i, input int b_r, input int b_i,
                      input bit conj, input bit acc, input bit last);
    in_valid = 1'b1;
    ar = a_r[AW-1:0];
    ai = a_i[AW-1:0];
    br = b_r[BW-1:0];
    bi = b_i[BW-1:0];
    conj_en = conj;
    acc_en  = acc;
    in_last = last;
    model_sample(a_r, a_i, b_r, b_i, conj, acc, last);
    @(posedge clk);
    #1;
    junk_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      junk_inputs();
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    exp2_q.delete();
    exp_cyc_q.delete();
    obs_q.delete();
    obs2_q.delete();
    obs_cyc_q.delete();
    obs2_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (pr !== '0) begin errors++; $display("FAIL reset_pr got=%h exp=0", pr); end
    checks++; if (pi !== '0) begin errors++; $display("FAIL reset_pi got=%h exp=0", pi); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_sticky); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [W-1:0] e, o, lit;
    int ec, oc;
    clear_q();
    send(3, 4, 5, 6, 1'b0, 1'b0, 1'b0);
    idle(10);
    lit = {1'b0, 24'hFFFFF7, 24'd38};
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== lit) begin
      errors++; $display("FAIL basic_literal got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : '0, lit);
    end
    for (int i = 0; i < 12; i++) begin
      send(rnd(-2000, 2000), rnd(-2000, 2000), rnd(-2000, 2000), rnd(-2000, 2000), 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL basic_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, o;
    int ec, oc;
    clear_q();
    for (int i = 0; i < 8; i++) send(3, 4, 5, 6, 1'(i % 2), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      send(rnd(-131072, 131071), rnd(-131072, 131071), rnd(-131072, 131071),
           rnd(-131072, 131071), 1'($urandom), 1'b0, 1'b0);
    idle(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL b2b_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] e, o;
    int ec, oc;
    clear_q();
    rst = 1'b1; idle(1); rst = 1'b0;   // start with ovf_sticky cleared
    send(-131072, -131072, -131072, -131072, 1'b0, 1'b0, 1'b0);
    idle(10);
    checks++; if (pi !== 24'd8388607) begin errors++; $display("FAIL sat_pi got=%h exp=7fffff", pi); end
    checks++; if (pr !== 24'd0) begin errors++; $display("FAIL sat_pr got=%h exp=0", pr); end
    checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", out_sat); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", ovf_sticky); end
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_clr got=%b exp=0", ovf_sticky); end
    send(100, -7, 3, 9, 1'b1, 1'b0, 1'b0);
    idle(10);
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_stay_clr got=%b exp=0", ovf_sticky); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL sat_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] e, o, lit;
    int ec, oc, len;
    clear_q();
    for (int i = 0; i < 4; i++) send(1, 0, 1, 1, 1'b0, 1'b1, 1'(i == 3));
    send(2, 0, 1, 0, 1'b0, 1'b1, 1'b1);
    idle(10);
    lit = {1'b0, 24'd4, 24'd4};
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== lit) begin
      errors++; $display("FAIL acc_literal got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : '0, lit);
    end
    for (int f = 0; f < 8; f++) begin
      len = rnd(1, 6);
      for (int s = 0; s < len; s++) begin
        send(rnd(-3000, 3000), rnd(-3000, 3000), rnd(-3000, 3000), rnd(-3000, 3000),
             1'($urandom), 1'b1, 1'(s == len - 1));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL acc_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL acc_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_abort_frame();
    logic [W-1:0] e, o, lit;
    int ec, oc;
    clear_q();
    send(1, 0, 1, 1, 1'b0, 1'b1, 1'b0);
    send(1, 0, 1, 1, 1'b0, 1'b1, 1'b0);
    send(1, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    send(1, 0, 1, 1, 1'b0, 1'b1, 1'b0);
    send(1, 0, 1, 1, 1'b0, 1'b1, 1'b1);
    idle(10);
    lit = {1'b0, 24'd1, 24'd0};
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== lit) begin
      errors++; $display("FAIL abort_literal got=%h exp=%h", (obs_q.size() > 0) ? obs_q[0] : '0, lit);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL abort_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] e, o, lit;
    int ec, oc;
    clear_q();
    send(1, 0, 6, 2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      send(rnd(-300, 300), rnd(-300, 300), rnd(-300, 300), rnd(-300, 300), 1'($urandom), 1'b0, 1'b0);
    send(1, 0, -6, -2, 1'b0, 1'b1, 1'b1);
    idle(10);
    lit = {1'b0, 24'd2, 24'd1};
    checks++;
    if (obs2_q.size() < 1 || obs2_q[0] !== lit) begin
      errors++; $display("FAIL shift_literal got=%h exp=%h", (obs2_q.size() > 0) ? obs2_q[0] : '0, lit);
    end
    checks++;
    if (obs2_q.size() != exp2_q.size()) begin errors++; $display("FAIL shift_count got=%0d exp=%0d", obs2_q.size(), exp2_q.size()); end
    while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
      e = exp2_q.pop_front(); o = obs2_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs2_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL shift_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [W-1:0] e, o;
    int ec, oc;
    clear_q();
    send(5, 6, 7, 8, 1'b0, 1'b0, 1'b0);
    send(9, 1, 2, 3, 1'b1, 1'b0, 1'b0);
    send(4, 4, 4, 4, 1'b0, 1'b1, 1'b0);   // leaves a frame open
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clear_q();
    m_open = 1'b0;
    idle(12);
    checks++; if (obs_q.size() != 0 || obs2_q.size() != 0) begin errors++; $display("FAIL flight_no_output got=%0d exp=0", obs_q.size() + obs2_q.size()); end
    checks++; if (pr !== '0 || pi !== '0) begin errors++; $display("FAIL flight_zero got=%h/%h exp=0/0", pr, pi); end
    // A fresh frame after reset must start from zero.
    send(2, 3, 1, 1, 1'b0, 1'b1, 1'b1);
    idle(10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL flight_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); ec = exp_cyc_q.pop_front(); oc = obs_cyc_q.pop_front();
      checks++;
      if (o !== e || oc != ec) begin errors++; $display("FAIL flight_result got=%h@%0d exp=%h@%0d", o, oc, e, ec); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    clr_ovf = 1'b0;
    junk_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_accumulate();
    test_abort_frame();
    test_shift();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
